// File: rtl/rr_reg_arbiter.sv
// ============================================================================
// Module   : rr_reg_arbiter
// Purpose  : Round-robin arbiter owning one WIDTH-bit register that is shared by
//            NREQ requesters. Each access is arbitrated, then granted/committed.
// Options  : `define RR_LOCK_EN adds a per-requester lock input.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_reg_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 4
) (
   input  logic                    clk,
   input  logic                    clr,
   input  logic [NREQ-1:0]         req,
   input  logic [2*NREQ-1:0]       cmd,
   input  logic [WIDTH*NREQ-1:0]   wdata,
`ifdef RR_LOCK_EN
   input  logic [NREQ-1:0]         lock,
`endif
   output logic [NREQ-1:0]         gnt,
   output logic [WIDTH-1:0]        q,
   output logic                    busy,
   output logic [7:0]              wr_count
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   localparam logic [1:0] c_CMD_LOAD = 2'b00;
   localparam logic [1:0] c_CMD_SET  = 2'b01;
   localparam logic [1:0] c_CMD_CLR  = 2'b10;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [NREQ-1:0]     r_gnt;
   logic [WIDTH-1:0]    r_q;
   logic                r_busy;
   logic [7:0]          r_wr_count;
   logic [1:0]          r_pend_cmd;
   logic [WIDTH-1:0]    r_pend_data;
   logic [IW-1:0]       r_last;
   logic [IW-1:0]       r_winner;

   logic                w_found;
   logic [IW-1:0]       w_win_idx;
   logic [1:0]          w_win_cmd;
   logic [WIDTH-1:0]    w_win_data;
   int                  w_idx;

   // Scan upward from the requester after the last winner, wrapping.
   always_comb begin
      w_found    = 1'b0;
      w_win_idx  = '0;
      w_win_cmd  = 2'b11;
      w_win_data = '0;
      w_idx      = 0;
      for (int k = 1; k <= NREQ; k++) begin
         w_idx = (int'(r_last) + k) % NREQ;
         if (!w_found && req[w_idx]) begin
            w_found    = 1'b1;
            w_win_idx  = IW'(w_idx);
            w_win_cmd  = cmd[2*w_idx +: 2];
            w_win_data = wdata[WIDTH*w_idx +: WIDTH];
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_found) w_state_nxt = GRANT;
         GRANT:   w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_gnt       <= '0;
         r_q         <= '0;
         r_busy      <= 1'b0;
         r_wr_count  <= '0;
         r_pend_cmd  <= '0;
         r_pend_data <= '0;
         r_last      <= IW'(NREQ - 1);
         r_winner    <= '0;
      end else if (r_state == IDLE) begin
         if (w_found) begin
            r_gnt       <= NREQ'(1) << w_win_idx;
            r_busy      <= 1'b1;
            r_pend_cmd  <= w_win_cmd;
            r_pend_data <= w_win_data;
            r_winner    <= w_win_idx;
         end
      end else begin
         case (r_pend_cmd)
            c_CMD_LOAD: r_q <= r_pend_data;
            c_CMD_SET:  r_q <= '1;
            c_CMD_CLR:  r_q <= '0;
            default:    r_q <= r_q;
         endcase
         if (r_pend_cmd != 2'b11) r_wr_count <= r_wr_count + 8'd1;
`ifdef RR_LOCK_EN
         // A locked winner keeps top priority: point just behind it.
         if (lock[r_winner])
            r_last <= (r_winner == '0) ? IW'(NREQ - 1) : r_winner - 1'b1;
         else
            r_last <= r_winner;
`else
         r_last <= r_winner;
`endif
         r_gnt  <= '0;
         r_busy <= 1'b0;
      end
   end

   assign gnt      = r_gnt;
   assign q        = r_q;
   assign busy     = r_busy;
   assign wr_count = r_wr_count;

endmodule

`default_nettype wire

// File: tb/tb_rr_reg_arbiter.sv
// ============================================================================
// Module   : tb_rr_reg_arbiter
// Purpose  : Directed self-checking bench for rr_reg_arbiter (NREQ=4, WIDTH=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_reg_arbiter;

   localparam int NREQ  = 4;
   localparam int WIDTH = 4;

   logic                  clk = 1'b0;
   logic                  clr = 1'b1;
   logic [NREQ-1:0]       req = '0;
   logic [2*NREQ-1:0]     cmd = '1;
   logic [WIDTH*NREQ-1:0] wdata = '0;
`ifdef RR_LOCK_EN
   logic [NREQ-1:0]       lock = '0;
`endif
   logic [NREQ-1:0]       gnt;
   logic [WIDTH-1:0]      q;
   logic                  busy;
   logic [7:0]            wr_count;

   int n_cmp = 0;
   int n_err = 0;

   rr_reg_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) u_dut (
      .clk      (clk),
      .clr      (clr),
      .req      (req),
      .cmd      (cmd),
      .wdata    (wdata),
`ifdef RR_LOCK_EN
      .lock     (lock),
`endif
      .gnt      (gnt),
      .q        (q),
      .busy     (busy),
      .wr_count (wr_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled on the negedge.
   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      clr = 1'b1;
      cyc();
      clr = 1'b0;
   endtask

   // One access from requester r: arbitration edge, then commit edge.
   task automatic access(input int r, input logic [1:0] c, input logic [3:0] d);
      req = '0;
      req[r] = 1'b1;
      cmd[2*r +: 2] = c;
      wdata[WIDTH*r +: WIDTH] = d;
      cyc();
      req = '0;
      cyc();
   endtask

   initial begin
      @(negedge clk);
      cyc();
      cyc();
      cyc();
      clr = 1'b0;
      chk("rst_q", 32'(q), 0);
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_wrc", 32'(wr_count), 0);

      // single load with latency and busy width
      req = 4'b0001; cmd[1:0] = 2'b00; wdata[3:0] = 4'h5;
      cyc();
      chk("load_gnt", 32'(gnt), 32'b0001);
      chk("load_busy", 32'(busy), 1);
      chk("load_q_pre", 32'(q), 0);
      req = '0;
      cyc();
      chk("load_q", 32'(q), 5);
      chk("load_wrc", 32'(wr_count), 1);
      chk("load_busy_off", 32'(busy), 0);
      chk("load_gnt_off", 32'(gnt), 0);
      cyc();
      chk("idle_busy", 32'(busy), 0);

      // round robin with all requesters held
      do_reset();
      req = 4'b1111; cmd = 8'h00;
      for (int i = 0; i < NREQ; i++) wdata[WIDTH*i +: WIDTH] = 4'(i + 1);
      for (int k = 0; k < 5; k++) begin
         cyc();
         chk($sformatf("rr_gnt%0d", k), 32'(gnt), 32'(1 << (k % 4)));
         cyc();
         chk($sformatf("rr_q%0d", k), 32'(q), 32'((k % 4) + 1));
         chk($sformatf("rr_gnt_low%0d", k), 32'(gnt), 0);
      end
      req = '0;
      chk("rr_wrc", 32'(wr_count), 5);

      // command set from requester 2
      access(2, 2'b01, 4'h3);
      chk("cmd_set_q", 32'(q), 32'hF);
      chk("cmd_set_wrc", 32'(wr_count), 6);
      access(2, 2'b10, 4'h3);
      chk("cmd_clr_q", 32'(q), 0);
      chk("cmd_clr_wrc", 32'(wr_count), 7);
      access(2, 2'b11, 4'h7);
      chk("cmd_nop_q", 32'(q), 0);
      chk("cmd_nop_wrc", 32'(wr_count), 7);
      access(2, 2'b00, 4'h9);
      chk("cmd_load_q", 32'(q), 9);
      chk("cmd_load_wrc", 32'(wr_count), 8);

      // reset in the middle of a grant discards the pending load
      req = 4'b0001; cmd[1:0] = 2'b00; wdata[3:0] = 4'hA;
      cyc();
      chk("midrst_gnt", 32'(gnt), 1);
      req = '0;
      clr = 1'b1;
      #1;
      chk("midrst_async_busy", 32'(busy), 0);
      chk("midrst_async_gnt", 32'(gnt), 0);
      chk("midrst_async_q", 32'(q), 0);
      cyc();
      clr = 1'b0;
      cyc();
      chk("midrst_q", 32'(q), 0);
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_wrc", 32'(wr_count), 0);

      // pointer at 3 (post reset), req=1001 must go to requester 0
      req = 4'b1001; cmd = 8'hFF;
      cyc();
      chk("wrap_ptr_gnt", 32'(gnt), 32'b0001);
      req = '0;
      cyc();
      chk("wrap_nop_wrc", 32'(wr_count), 0);

      // 256 committed loads wrap the counter
      for (int i = 0; i < 255; i++) access(1, 2'b00, 4'(i));
      chk("wrap_wrc255", 32'(wr_count), 255);
      chk("wrap_q", 32'(q), 32'hE);
      access(1, 2'b00, 4'hC);
      chk("wrap_wrc0", 32'(wr_count), 0);
      chk("wrap_q_last", 32'(q), 32'hC);

`ifdef RR_LOCK_EN
      do_reset();
      req = 4'b0011; cmd = 8'h00;
      cyc();
      chk("lock_g0", 32'(gnt), 32'b0001);
      cyc();
      cyc();
      chk("lock_g1", 32'(gnt), 32'b0010);
      lock = 4'b0010;
      cyc();
      cyc();
      chk("lock_g1_again", 32'(gnt), 32'b0010);
      cyc();
      cyc();
      chk("lock_g1_third", 32'(gnt), 32'b0010);
      lock = '0;
      cyc();
      cyc();
      chk("lock_release_g0", 32'(gnt), 32'b0001);
      req = '0;
      cyc();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
